// File: rtl/shreg_pkg.sv
// Shared encodings for the universal shift register: shift modes and sequencer states.
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step shifter shared by the en path and the sequencer path.
// Mode 11 rotates left when SHREG_ROTATE_EN is defined, otherwise it holds (shifted=0).
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  mode_e            mode,
  input  logic             sh_in_l,
  input  logic             sh_in_r,
  output logic [WIDTH-1:0] nxt,
  output logic             expelled,
  output logic             shifted
);

  always_comb begin
    nxt      = cur;
    expelled = 1'b0;
    shifted  = 1'b1;
    case (mode)
      MODE_LSL: begin
        nxt      = {cur[WIDTH-2:0], sh_in_r};
        expelled = cur[WIDTH-1];
      end
      MODE_LSR: begin
        nxt      = {sh_in_l, cur[WIDTH-1:1]};
        expelled = cur[0];
      end
      MODE_ASR: begin
        nxt      = {cur[WIDTH-1], cur[WIDTH-1:1]};
        expelled = cur[0];
      end
      default: begin
`ifdef SHREG_ROTATE_EN
        nxt      = {cur[WIDTH-2:0], cur[WIDTH-1]};
        expelled = cur[WIDTH-1];
`else
        shifted  = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register with parallel load, single-step shifts and an N-step sequencer.
// Optional rotate mode is enabled by defining SHREG_ROTATE_EN.
module univ_shift_register
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic             sh_in_r,
  input  logic             sh_in_l,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             sh_out,
  output logic             busy,
  output logic             done
);

  state_e           state, state_nxt;
  mode_e            mode_lat;
  logic [CNT_W-1:0] remaining;

  logic             step_run, step_en, launch;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_val;
  logic             step_bit, step_shifted;

  // A load in IDLE also suppresses start and en: load has top priority.
  assign step_run  = (state == ST_RUN) && !load;
  assign launch    = (state == ST_IDLE) && start && !load;
  assign step_en   = (state == ST_IDLE) && en && !start && !load;
  assign step_mode = (state == ST_RUN) ? mode_lat : mode_e'(mode);

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .cur      (out),
    .mode     (step_mode),
    .sh_in_l  (sh_in_l),
    .sh_in_r  (sh_in_r),
    .nxt      (step_val),
    .expelled (step_bit),
    .shifted  (step_shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (launch) state_nxt = (count == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (load)                           state_nxt = ST_IDLE;
        else if (remaining == CNT_W'(1))    state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      sh_out    <= 1'b0;
      remaining <= '0;
      mode_lat  <= MODE_LSL;
    end else begin
      if (load) begin
        out <= in;
      end else if (step_run || step_en) begin
        out <= step_val;
        if (step_shifted) sh_out <= step_bit;
      end

      if (launch) begin
        remaining <= count;
        mode_lat  <= mode_e'(mode);
      end else if (step_run) begin
        remaining <= remaining - CNT_W'(1);
      end else if (state == ST_RUN) begin
        remaining <= '0;  // aborted by load
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
